// File: rtl/execute_stage.sv
// execute_stage: single-cycle execute unit of a 16-bit pipeline.
// Computes the ALU result, the next PC, the {Z,N,V} flags and an
// illegal-opcode indication from the current inputs, then registers them
// (latency exactly one cycle, a new operation every cycle).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears all outputs)
//   PC2             incremented PC of the instruction
//   Rd1, Rd2, Imm   operand A, register operand B, extended immediate
//   ALUOp, ALUF     opcode and R-type function field
//   ALUSrc          1: operand B = Imm, 0: operand B = Rd2
//   Branch          conditional-branch qualifier
//   ALUO, PCS       registered ALU result and next PC
//   flag            registered {Z, N, V}
//   err             registered illegal-opcode indication
//
// Build option: EXECUTE_STAGE_ERR_EN -- when defined, illegal opcodes raise
// err; when undefined, err is held at 0.
module execute_stage #(
    localparam int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] PC2,
    input  logic [W-1:0] Rd1,
    input  logic [W-1:0] Rd2,
    input  logic [W-1:0] Imm,
    input  logic [4:0]   ALUOp,
    input  logic [1:0]   ALUF,
    input  logic         ALUSrc,
    input  logic         Branch,
    output logic [W-1:0] ALUO,
    output logic [W-1:0] PCS,
    output logic [2:0]   flag,
    output logic         err
);

    // Rotate/shift: sel 00 rol, 01 sll, 10 ror, 11 srl. A shift by W yields 0,
    // so the rotate wrap term vanishes for amt = 0.
    function automatic logic [W-1:0] shift_op(input logic [W-1:0] val,
                                              input logic [3:0]   amt,
                                              input logic [1:0]   sel);
        logic [4:0] inv;
        inv = 5'(W) - {1'b0, amt};
        case (sel)
            2'b00:   return (val << amt) | (val >> inv);
            2'b01:   return val << amt;
            2'b10:   return (val >> amt) | (val << inv);
            default: return val >> amt;
        endcase
    endfunction

    logic [W-1:0] a, b, sub_res, addr, br_tgt, rev, arith_res, shift_res;
    logic [W:0]   add_full;
    logic [3:0]   sh;
    logic [1:0]   arith_sel, shift_sel;
    logic         add_v, sub_v, addr_v, arith_v, br_cond, cmp_res;
    logic [W-1:0] alu_c, pcs_c;
    logic         v_c, err_c;

    // Operand selection and shared datapath terms
    assign a        = Rd1;
    assign b        = ALUSrc ? Imm : Rd2;
    assign sh       = b[3:0];
    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_res  = b - a;
    assign addr     = Rd1 + Imm;
    assign br_tgt   = PC2 + Imm;

    // Two's-complement overflow: like-signed operands, result sign differs
    assign add_v  = (a[W-1] == b[W-1]) && (add_full[W-1] != a[W-1]);
    assign sub_v  = (b[W-1] != a[W-1]) && (sub_res[W-1] != b[W-1]);
    assign addr_v = (Rd1[W-1] == Imm[W-1]) && (addr[W-1] != Rd1[W-1]);

    // Immediate forms encode the sub-operation in ALUOp[1:0]; R-types use ALUF
    assign arith_sel = ALUOp[4] ? ALUF : ALUOp[1:0];
    assign shift_sel = ALUOp[3] ? ALUF : ALUOp[1:0];
    assign shift_res = shift_op(a, sh, shift_sel);

    // Add/sub/xor/andn with overflow for the arithmetic pair only
    always_comb begin
        arith_res = '0;
        arith_v   = 1'b0;
        case (arith_sel)
            2'b00:   begin arith_res = add_full[W-1:0]; arith_v = add_v; end
            2'b01:   begin arith_res = sub_res;         arith_v = sub_v; end
            2'b10:   arith_res = a ^ b;
            default: arith_res = a & ~b;
        endcase
    end

    // Set-on-condition: seq, slt, sle, sco
    always_comb begin
        cmp_res = 1'b0;
        case (ALUOp[1:0])
            2'b00:   cmp_res = (a == b);
            2'b01:   cmp_res = ($signed(a) < $signed(b));
            2'b10:   cmp_res = ($signed(a) <= $signed(b));
            default: cmp_res = add_full[W];
        endcase
    end

    // Branch condition on Rd1: beqz, bnez, bltz, bgez
    always_comb begin
        br_cond = 1'b0;
        case (ALUOp[1:0])
            2'b00:   br_cond = (Rd1 == '0);
            2'b01:   br_cond = (Rd1 != '0);
            2'b10:   br_cond = Rd1[W-1];
            default: br_cond = ~Rd1[W-1];
        endcase
    end

    // Bit reversal of Rd1
    always_comb begin
        rev = '0;
        for (int unsigned i = 0; i < W; i++) rev[i] = Rd1[W-1-i];
    end

    // Opcode decode; unlisted or unknown opcodes fall to the illegal default
    always_comb begin
        alu_c = '0;
        pcs_c = PC2;
        v_c   = 1'b0;
        err_c = 1'b0;
        case (ALUOp)
            5'b00000, 5'b00001: ;
            5'b00100: pcs_c = br_tgt;
            5'b00101: pcs_c = addr;
            5'b00110: begin pcs_c = br_tgt; alu_c = PC2; end
            5'b00111: begin pcs_c = addr;   alu_c = PC2; end
            5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b11011: begin
                alu_c = arith_res;
                v_c   = arith_v;
            end
            5'b01100, 5'b01101, 5'b01110, 5'b01111: begin
                if (Branch && br_cond) pcs_c = br_tgt;
            end
            5'b10000, 5'b10001, 5'b10011: begin
                alu_c = addr;
                v_c   = addr_v;
            end
            5'b10010: alu_c = {Rd1[7:0], Imm[7:0]};
            5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b11010: alu_c = shift_res;
            5'b11000: alu_c = Imm;
            5'b11001: alu_c = rev;
            5'b11100, 5'b11101, 5'b11110, 5'b11111: alu_c = {{(W-1){1'b0}}, cmp_res};
            default: begin
`ifdef EXECUTE_STAGE_ERR_EN
                err_c = 1'b1;
`else
                err_c = 1'b0;
`endif
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUO <= '0;
            PCS  <= '0;
            flag <= '0;
            err  <= 1'b0;
        end else begin
            ALUO <= alu_c;
            PCS  <= pcs_c;
            flag <= {(alu_c == '0), alu_c[W-1], v_c};
            err  <= err_c;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed vectors with literal expectations,
// a reset check, then randomized vectors against an integer reference model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] PC2, Rd1, Rd2, Imm;
    logic [4:0]  ALUOp;
    logic [1:0]  ALUF;
    logic        ALUSrc, Branch;
    logic [15:0] ALUO, PCS;
    logic [2:0]  flag;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] pcs;
        logic [2:0]  flg;
        logic        err;
    } res_t;

`ifdef EXECUTE_STAGE_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    execute_stage dut (
        .clk(clk), .rst_n(rst_n), .PC2(PC2), .Rd1(Rd1), .Rd2(Rd2), .Imm(Imm),
        .ALUOp(ALUOp), .ALUF(ALUF), .ALUSrc(ALUSrc), .Branch(Branch),
        .ALUO(ALUO), .PCS(PCS), .flag(flag), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    // Reference model: plain integer arithmetic on the opcode table
    function automatic res_t model(input logic [15:0] pc2, rd1, rd2, imm,
                                   input logic [4:0] op, input logic [1:0] f,
                                   input logic src, input logic br);
        int   a, b, o, sh, r, pcs, k, s, t;
        bit   v, e;
        res_t res;
        a = int'(rd1); b = src ? int'(imm) : int'(rd2); o = int'(op);
        sh = b % 16; r = 0; pcs = int'(pc2); v = 0; e = 0;
        if (o == 0 || o == 1) begin
        end else if (o == 4) pcs = pc2 + imm;
        else if (o == 5) pcs = rd1 + imm;
        else if (o == 6) begin pcs = pc2 + imm; r = pc2; end
        else if (o == 7) begin pcs = rd1 + imm; r = pc2; end
        else if ((o >= 8 && o <= 11) || o == 27) begin
            k = (o == 27) ? int'(f) : o - 8;
            if (k == 0) begin r = a + b; s = sgn(a) + sgn(b); v = (s > 32767 || s < -32768); end
            else if (k == 1) begin r = b - a; s = sgn(b) - sgn(a); v = (s > 32767 || s < -32768); end
            else if (k == 2) r = a ^ b;
            else r = a & (~b);
        end else if (o >= 12 && o <= 15) begin
            t = (o == 12) ? (a == 0) : (o == 13) ? (a != 0) : (o == 14) ? (sgn(a) < 0) : (sgn(a) >= 0);
            if (br && t != 0) pcs = pc2 + imm;
        end else if (o == 16 || o == 17 || o == 19) begin
            r = rd1 + imm; s = sgn(int'(rd1)) + sgn(int'(imm)); v = (s > 32767 || s < -32768);
        end else if (o == 18) r = ((a & 255) * 256) + (int'(imm) & 255);
        else if ((o >= 20 && o <= 23) || o == 26) begin
            k = (o == 26) ? int'(f) : o - 20;
            r = a;
            for (int i = 0; i < sh; i++) begin
                if (k == 0) r = ((r * 2) & 16'hFFFF) + (r / 32768);
                else if (k == 1) r = (r * 2) & 16'hFFFF;
                else if (k == 2) r = (r / 2) + ((r % 2) * 32768);
                else r = r / 2;
            end
        end else if (o == 24) r = imm;
        else if (o == 25) begin
            for (int i = 0; i < 16; i++) if (((a >> i) & 1) == 1) r = r + (1 << (15 - i));
        end else if (o == 28) r = (a == b) ? 1 : 0;
        else if (o == 29) r = (sgn(a) < sgn(b)) ? 1 : 0;
        else if (o == 30) r = (sgn(a) <= sgn(b)) ? 1 : 0;
        else if (o == 31) r = (a + b > 65535) ? 1 : 0;
        else e = ERR_EXP;
        r   = r & 16'hFFFF;
        pcs = pcs & 16'hFFFF;
        res.alu = 16'(r);
        res.pcs = 16'(pcs);
        res.flg = {(r == 0), (r >= 32768), v};
        res.err = e;
        return res;
    endfunction

    // Drive one operation (called just after a falling edge), sample after the next rising edge
    task automatic step(input logic [15:0] pc2, rd1, rd2, imm, input logic [4:0] op,
                        input logic [1:0] f, input logic src, input logic br, output res_t got);
        PC2 = pc2; Rd1 = rd1; Rd2 = rd2; Imm = imm;
        ALUOp = op; ALUF = f; ALUSrc = src; Branch = br;
        @(posedge clk);
        @(negedge clk);
        got = {ALUO, PCS, flag, err};
    endtask

    task automatic check_res(input string tag, input res_t got, input res_t exp);
        check({tag, " ALUO"}, 32'(got.alu), 32'(exp.alu));
        check({tag, " PCS"},  32'(got.pcs), 32'(exp.pcs));
        check({tag, " flag"}, 32'(got.flg), 32'(exp.flg));
        check({tag, " err"},  32'(got.err), 32'(exp.err));
    endtask

    initial begin
        res_t got;
        logic [15:0] r_pc2, r_rd1, r_rd2, r_imm;
        logic [4:0]  r_op;
        logic [1:0]  r_f;
        logic        r_src, r_br;

        rst_n = 1'b0;
        PC2 = '0; Rd1 = '0; Rd2 = '0; Imm = '0;
        ALUOp = '0; ALUF = '0; ALUSrc = 1'b0; Branch = 1'b0;
        #1;
        check_res("reset", {ALUO, PCS, flag, err}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with literal expected values
        step(16'h0002, 16'h0001, 16'h0000, 16'h0004, 5'b01000, 2'b00, 1'b1, 1'b0, got);
        check_res("addi", got, {16'h0005, 16'h0002, 3'b000, 1'b0});
        step(16'h0002, 16'h0006, 16'h0000, 16'h0004, 5'b01001, 2'b00, 1'b1, 1'b0, got);
        check_res("subi", got, {16'hFFFE, 16'h0002, 3'b010, 1'b0});
        step(16'h0002, 16'h0006, 16'h0000, 16'h0004, 5'b01010, 2'b00, 1'b1, 1'b0, got);
        check("xori ALUO", 32'(got.alu), 32'h0002);
        step(16'h0002, 16'h0006, 16'h0000, 16'h0004, 5'b01011, 2'b00, 1'b1, 1'b0, got);
        check("andni ALUO", 32'(got.alu), 32'h0002);
        step(16'h0002, 16'h0006, 16'h0000, 16'h0004, 5'b10100, 2'b00, 1'b1, 1'b0, got);
        check("roli ALUO", 32'(got.alu), 32'h0060);
        step(16'h0002, 16'h0006, 16'h0000, 16'h0004, 5'b10101, 2'b00, 1'b1, 1'b0, got);
        check("slli ALUO", 32'(got.alu), 32'h0060);
        step(16'h0002, 16'h0006, 16'h0000, 16'h0004, 5'b10110, 2'b00, 1'b1, 1'b0, got);
        check("rori ALUO", 32'(got.alu), 32'h6000);
        step(16'h0002, 16'h0006, 16'h0000, 16'h0004, 5'b10111, 2'b00, 1'b1, 1'b0, got);
        check_res("srli", got, {16'h0000, 16'h0002, 3'b100, 1'b0});
        step(16'h0002, 16'h0000, 16'h0000, 16'h0010, 5'b01100, 2'b00, 1'b0, 1'b1, got);
        check_res("beqz taken", got, {16'h0000, 16'h0012, 3'b100, 1'b0});
        step(16'h0002, 16'h0000, 16'h0000, 16'h0010, 5'b01100, 2'b00, 1'b0, 1'b0, got);
        check("beqz nobranch PCS", 32'(got.pcs), 32'h0002);
        step(16'h0002, 16'h0001, 16'h8000, 16'h0000, 5'b11011, 2'b01, 1'b0, 1'b0, got);
        check_res("sub ovf", got, {16'h7FFF, 16'h0002, 3'b001, 1'b0});
        step(16'h0004, 16'h1234, 16'h5678, 16'h9ABC, 5'b00010, 2'b00, 1'b0, 1'b0, got);
        check_res("illegal", got, {16'h0000, 16'h0004, 3'b100, ERR_EXP});

        // Asynchronous reset while outputs are nonzero, then release
        step(16'h0002, 16'h0001, 16'h0000, 16'h0004, 5'b01000, 2'b00, 1'b1, 1'b0, got);
        check("pre-reset ALUO", 32'(got.alu), 32'h0005);
        #2 rst_n = 1'b0;
        #1 check_res("async reset", {ALUO, PCS, flag, err}, '0);
        @(negedge clk);
        check_res("held reset", {ALUO, PCS, flag, err}, '0);
        rst_n = 1'b1;
        step(16'h0008, 16'h0006, 16'h0000, 16'h0004, 5'b01010, 2'b00, 1'b1, 1'b0, got);
        check_res("post-reset", got, {16'h0002, 16'h0008, 3'b000, 1'b0});

        // Randomized vectors against the reference model
        for (int n = 0; n < 400; n++) begin
            r_pc2 = 16'($urandom); r_rd1 = 16'($urandom);
            r_rd2 = 16'($urandom); r_imm = 16'($urandom);
            if ($urandom_range(0, 7) == 0) r_rd1 = 16'h0000;
            if ($urandom_range(0, 7) == 0) r_rd2 = r_rd1;
            r_op  = 5'($urandom_range(0, 31));
            r_f   = 2'($urandom_range(0, 3));
            r_src = 1'($urandom_range(0, 1));
            r_br  = 1'($urandom_range(0, 1));
            step(r_pc2, r_rd1, r_rd2, r_imm, r_op, r_f, r_src, r_br, got);
            check_res($sformatf("rand%0d op%0d", n, r_op), got,
                      model(r_pc2, r_rd1, r_rd2, r_imm, r_op, r_f, r_src, r_br));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
